// File: rtl/dcache_arb_pkg.sv
// Shared definitions for the dcache memory request arbiter: requester slots
// and the per-TID tracking entry.
package dcache_arb_pkg;

    localparam int LOAD_IDX = 0;
    localparam int WBUF_IDX = 1;
    localparam int AMO_IDX  = 2;
    localparam int OWNER_W  = 4;

    typedef struct packed {
        logic               in_use;
        logic [OWNER_W-1:0] owner;
        logic               we;
    } tid_entry_t;

    // AMO always occupies the highest requester slot
    function automatic int amo_idx(input int num_req);
        return num_req - 1;
    endfunction

endpackage

// File: rtl/dcache_mem_req_arbiter_tid_pool.sv
// TID pool: per-TID owner/we table, registered free mask and a lowest-free
// priority encoder for allocation.
module tid_pool
    import dcache_arb_pkg::*;
#(
    parameter int TID_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 alloc_i,
    input  logic [OWNER_W-1:0]   alloc_owner_i,
    input  logic                 alloc_we_i,
    output logic [TID_WIDTH-1:0] alloc_tid_o,
    input  logic                 free_i,
    input  logic [TID_WIDTH-1:0] free_tid_i,
    input  logic [TID_WIDTH-1:0] lookup_tid_i,
    output tid_entry_t           lookup_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int NUM_TID = 1 << TID_WIDTH;

    tid_entry_t [NUM_TID-1:0] tbl;
    logic       [NUM_TID-1:0] free_mask;

    genvar t;
    for (t = 0; t < NUM_TID; t++) begin : g_mask
        assign free_mask[t] = ~tbl[t].in_use;
    end

    always_comb begin
        alloc_tid_o = '0;
        for (int i = NUM_TID - 1; i >= 0; i--) begin
            if (free_mask[i]) alloc_tid_o = TID_WIDTH'(i);
        end
    end

    assign lookup_o = tbl[lookup_tid_i];
    assign full_o   = ~|free_mask;
    assign empty_o  = &free_mask;

    // Free and alloc never target the same TID: alloc picks from the
    // registered free mask, free only ever hits an in-use entry.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tbl <= '0;
        end else begin
            if (free_i) tbl[free_tid_i].in_use <= 1'b0;
            if (alloc_i) tbl[alloc_tid_o] <= '{in_use: 1'b1, owner: alloc_owner_i, we: alloc_we_i};
        end
    end

endmodule

// File: rtl/dcache_mem_req_arbiter.sv
// Round-robin arbiter sharing the dcache memory request port between load-miss,
// write-buffer and AMO requesters, with TID allocation and response routing.
module dcache_mem_req_arbiter
    import dcache_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int TID_WIDTH      = 4,
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int MAX_OUT_STORES = 7
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ-1:0]            req_we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
    output logic                          mem_req_valid_o,
    input  logic                          mem_req_ready_i,
    output logic [TID_WIDTH-1:0]          mem_req_tid_o,
    output logic                          mem_req_we_o,
    output logic [ADDR_WIDTH-1:0]         mem_req_addr_o,
    output logic [DATA_WIDTH-1:0]         mem_req_wdata_o,
    input  logic                          mem_rsp_valid_i,
    input  logic [TID_WIDTH-1:0]          mem_rsp_tid_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [TID_WIDTH-1:0]          rsp_tid_o,
    output logic                          idle_o,
    output logic                          tid_err_o
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AMO_REQ = amo_idx(NUM_REQ);
    localparam int CNT_W   = TID_WIDTH + 1;

    logic [CNT_W-1:0]      store_cnt;
    logic                  out_valid;
    logic [TID_WIDTH-1:0]  out_tid;
    logic                  out_we;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_wdata;
    logic [IDX_W-1:0]      rr_ptr;
    logic                  amo_busy;
    logic                  tid_err;

    logic                  can_load;
    logic                  store_ok;
    logic [NUM_REQ-1:0]    elig;
    logic                  gnt_valid;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  gnt_we;
    logic                  gnt_is_amo;
    logic [TID_WIDTH-1:0]  alloc_tid;
    logic                  pool_full;
    logic                  pool_empty;
    tid_entry_t            rsp_entry;
    logic                  rsp_hit;

    tid_pool #(.TID_WIDTH(TID_WIDTH)) u_tid_pool (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .alloc_i       (gnt_valid),
        .alloc_owner_i (OWNER_W'(gnt_idx)),
        .alloc_we_i    (gnt_we),
        .alloc_tid_o   (alloc_tid),
        .free_i        (rsp_hit),
        .free_tid_i    (mem_rsp_tid_i),
        .lookup_tid_i  (mem_rsp_tid_i),
        .lookup_o      (rsp_entry),
        .full_o        (pool_full),
        .empty_o       (pool_empty)
    );

    // A grant always loads the output register, so it needs a free slot there.
    assign can_load = !out_valid || mem_req_ready_i;
    assign store_ok = store_cnt < CNT_W'(MAX_OUT_STORES);

    genvar i;
    for (i = 0; i < NUM_REQ; i++) begin : g_elig
        logic base_ok;
        assign base_ok = rst_ni && req_valid_i[i] && !pool_full && !amo_busy
                         && can_load && (!req_we_i[i] || store_ok);
        if (i == AMO_REQ) begin : g_amo
            assign elig[i] = base_ok && pool_empty;
        end else begin : g_std
            assign elig[i] = base_ok;
        end
    end

    always_comb begin
        int idx;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gnt_valid && elig[IDX_W'(idx)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(idx);
            end
        end
    end

    assign gnt_we      = req_we_i[gnt_idx];
    assign gnt_is_amo  = gnt_idx == IDX_W'(AMO_REQ);
    assign req_ready_o = gnt_valid ? (NUM_REQ'(1) << gnt_idx) : '0;

    assign rsp_hit     = rst_ni && mem_rsp_valid_i && rsp_entry.in_use;
    assign rsp_valid_o = rsp_hit ? (NUM_REQ'(1) << rsp_entry.owner) : '0;
    assign rsp_tid_o   = rsp_hit ? mem_rsp_tid_i : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            store_cnt <= '0;
            out_valid <= 1'b0;
            out_tid   <= '0;
            out_we    <= 1'b0;
            out_addr  <= '0;
            out_wdata <= '0;
            rr_ptr    <= '0;
            amo_busy  <= 1'b0;
            tid_err   <= 1'b0;
        end else begin
            case ({gnt_valid && gnt_we, rsp_hit && rsp_entry.we})
                2'b10:   store_cnt <= store_cnt + 1'b1;
                2'b01:   store_cnt <= store_cnt - 1'b1;
                default: store_cnt <= store_cnt;
            endcase

            if (gnt_valid) begin
                out_valid <= 1'b1;
                out_tid   <= alloc_tid;
                out_we    <= gnt_we;
                out_addr  <= req_addr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                out_wdata <= req_wdata_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                rr_ptr    <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end else if (mem_req_ready_i) begin
                out_valid <= 1'b0;
            end

            // The AMO owns its TID from grant to response; that window is the
            // whole exclusivity period.
            if (rsp_hit && rsp_entry.owner == OWNER_W'(AMO_REQ)) amo_busy <= 1'b0;
            if (gnt_valid && gnt_is_amo) amo_busy <= 1'b1;

            if (mem_rsp_valid_i && !rsp_entry.in_use) tid_err <= 1'b1;
        end
    end

    assign mem_req_valid_o = out_valid;
    assign mem_req_tid_o   = out_tid;
    assign mem_req_we_o    = out_we;
    assign mem_req_addr_o  = out_addr;
    assign mem_req_wdata_o = out_wdata;
    assign idle_o          = pool_empty && !out_valid;
    assign tid_err_o       = tid_err;

endmodule

// File: tb/tb_dcache_mem_req_arbiter.sv
// Directed scenarios plus random traffic, checked every cycle against a
// transaction-level model of the arbiter (TID table, output slot, RR pointer).
module tb_dcache_mem_req_arbiter;

    localparam int NTID = 16;

    logic         clk;
    logic         rst_n;
    logic [2:0]   req_valid, req_we, req_ready_o;
    logic [191:0] req_addr, req_wdata;
    logic         mem_req_valid_o, mem_req_ready, mem_req_we_o;
    logic [3:0]   mem_req_tid_o;
    logic [63:0]  mem_req_addr_o, mem_req_wdata_o;
    logic         mem_rsp_valid;
    logic [3:0]   mem_rsp_tid;
    logic [2:0]   rsp_valid_o;
    logic [3:0]   rsp_tid_o;
    logic         idle_o, tid_err_o;

    dcache_mem_req_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready),
        .mem_req_tid_o(mem_req_tid_o), .mem_req_we_o(mem_req_we_o),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_wdata_o(mem_req_wdata_o),
        .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_tid_i(mem_rsp_tid),
        .rsp_valid_o(rsp_valid_o), .rsp_tid_o(rsp_tid_o),
        .idle_o(idle_o), .tid_err_o(tid_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    // model state
    bit          m_use[NTID];
    int          m_own[NTID];
    bit          m_we[NTID];
    bit          m_ov, m_owe, m_err;
    logic [3:0]  m_otid;
    logic [63:0] m_oaddr, m_odata;
    int          m_rr;

    logic [2:0]  last_ready;
    int          issued[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int t = 0; t < NTID; t++) begin
            m_use[t] = 0; m_own[t] = 0; m_we[t] = 0;
        end
        m_ov = 0; m_owe = 0; m_err = 0; m_otid = '0;
        m_oaddr = '0; m_odata = '0; m_rr = 0;
    endfunction

    // One clock: check all outputs at the falling edge, advance the model at
    // the rising edge, return 1 time unit later so callers can drive inputs.
    task automatic cycle();
        int  nfree, nst, ltid, g, idx;
        bit  amo, canl, hit;
        bit  el[3];
        @(negedge clk);
        nfree = 0; nst = 0; ltid = -1; amo = 0;
        for (int t = 0; t < NTID; t++) begin
            if (!m_use[t]) begin
                nfree++;
                if (ltid < 0) ltid = t;
            end else begin
                if (m_we[t]) nst++;
                if (m_own[t] == 2) amo = 1;
            end
        end
        canl = !m_ov || mem_req_ready;
        for (int r = 0; r < 3; r++)
            el[r] = rst_n && req_valid[r] && nfree > 0 && (!req_we[r] || nst < 7)
                    && !amo && canl && (r != 2 || nfree == NTID);
        g = -1;
        for (int k = 0; k < 3; k++) begin
            idx = (m_rr + k) % 3;
            if (g < 0 && el[idx]) g = idx;
        end
        hit = rst_n && mem_rsp_valid && m_use[mem_rsp_tid];
        last_ready = req_ready_o;
        chk("req_ready", 64'(req_ready_o), (g < 0) ? 64'd0 : (64'd1 << g));
        chk("rsp_valid", 64'(rsp_valid_o), hit ? (64'd1 << m_own[mem_rsp_tid]) : 64'd0);
        if (hit) chk("rsp_tid", 64'(rsp_tid_o), 64'(mem_rsp_tid));
        chk("mem_valid", 64'(mem_req_valid_o), 64'(m_ov));
        if (m_ov) begin
            chk("mem_tid", 64'(mem_req_tid_o), 64'(m_otid));
            chk("mem_we", 64'(mem_req_we_o), 64'(m_owe));
            chk("mem_addr", mem_req_addr_o, m_oaddr);
            chk("mem_wdata", mem_req_wdata_o, m_odata);
        end
        chk("idle", 64'(idle_o), 64'(nfree == NTID && !m_ov));
        chk("tid_err", 64'(tid_err_o), 64'(m_err));
        if (mem_req_valid_o === 1'b1 && mem_req_ready) issued.push_back(int'(mem_req_tid_o));
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (mem_rsp_valid && !m_use[mem_rsp_tid]) m_err = 1;
            if (hit) m_use[mem_rsp_tid] = 0;
            if (m_ov && mem_req_ready) m_ov = 0;
            if (g >= 0) begin
                m_use[ltid] = 1; m_own[ltid] = g; m_we[ltid] = req_we[g];
                m_ov = 1; m_otid = 4'(ltid); m_owe = req_we[g];
                m_oaddr = req_addr[g*64 +: 64];
                m_odata = req_wdata[g*64 +: 64];
                m_rr = (g + 1) % 3;
            end
        end
        #1;
    endtask

    // Respond to outstanding TIDs (optionally sparing the AMO) one per cycle.
    // With stop_on_amo the loop ends when the AMO is granted.
    task automatic respond_all(input bit stop_on_amo, output bit done);
        int pick;
        bit busy;
        done = 0;
        for (int n = 0; n < 100 && !done; n++) begin
            pick = -1; busy = m_ov;
            for (int t = NTID - 1; t >= 0; t--) begin
                if (m_use[t]) busy = 1;
                if (m_use[t] && !(m_ov && m_otid == 4'(t)) && !(stop_on_amo && m_own[t] == 2))
                    pick = t;
            end
            if (!stop_on_amo && !busy) begin
                done = 1;
            end else begin
                mem_rsp_valid = (pick >= 0);
                mem_rsp_tid   = (pick >= 0) ? 4'(pick) : 4'd0;
                cycle();
                if (stop_on_amo && last_ready == 3'b100) done = 1;
            end
        end
        mem_rsp_valid = 0;
    endtask

    task automatic drain();
        bit done;
        req_valid = '0; mem_req_ready = 1;
        respond_all(1'b0, done);
        chk("drain_done", 64'(done), 64'd1);
    endtask

    initial begin
        bit done;
        int amo_tid;
        logic [63:0] hold_addr;
        rst_n = 0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_tid = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cycle();
        chk("rst_mem_valid", 64'(mem_req_valid_o), 64'd0);
        chk("rst_mem_addr", mem_req_addr_o, 64'd0);
        chk("rst_idle", 64'(idle_o), 64'd1);
        chk("rst_tid_err", 64'(tid_err_o), 64'd0);
        rst_n = 1;

        // single load
        req_valid = 3'b001; req_we = 3'b000; req_addr[63:0] = 64'h8000_0040;
        mem_req_ready = 1;
        cycle();
        req_valid = '0;
        chk("t1_issue_valid", 64'(mem_req_valid_o), 64'd1);
        chk("t1_issue_tid", 64'(mem_req_tid_o), 64'd0);
        chk("t1_issue_we", 64'(mem_req_we_o), 64'd0);
        chk("t1_issue_addr", mem_req_addr_o, 64'h8000_0040);
        cycle();
        mem_rsp_valid = 1; mem_rsp_tid = 4'd0;
        #1 chk("t1_rsp_route", 64'(rsp_valid_o), 64'b001);
        cycle();
        mem_rsp_valid = 0;
        chk("t1_idle", 64'(idle_o), 64'd1);

        // round robin with AMO held off by outstanding traffic
        req_valid = 3'b111; req_we = 3'b010;
        req_addr = {64'h3000, 64'h2000, 64'h1000};
        req_wdata = {64'hA3A3, 64'hB2B2, 64'hC1C1};
        for (int c = 0; c < 6; c++) begin
            cycle();
            chk("t2_rr", 64'(last_ready), (c % 2 == 0) ? 64'b010 : 64'b001);
        end
        req_valid = 3'b100;
        respond_all(1'b1, done);
        chk("t2_amo_granted", 64'(done), 64'd1);
        req_valid = 3'b011;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("t2_amo_excl", 64'(last_ready), 64'd0);
        end
        amo_tid = -1;
        for (int t = 0; t < NTID; t++) if (m_use[t] && m_own[t] == 2) amo_tid = t;
        chk("t2_amo_tracked", 64'(amo_tid >= 0), 64'd1);
        mem_rsp_valid = 1; mem_rsp_tid = 4'(amo_tid);
        #1 chk("t2_amo_rsp", 64'(rsp_valid_o), 64'b100);
        cycle();
        mem_rsp_valid = 0;
        cycle();
        chk("t2_after_amo", 64'(last_ready != 3'b000), 64'd1);
        drain();

        // store limit
        issued.delete();
        req_valid = 3'b010; req_we = 3'b010;
        repeat (10) cycle();
        chk("t3_issued_cnt", 64'(issued.size()), 64'd7);
        for (int k = 0; k < 7 && k < issued.size(); k++) chk("t3_tid_seq", 64'(issued[k]), 64'(k));
        chk("t3_stall", 64'(req_ready_o), 64'd0);
        mem_rsp_valid = 1; mem_rsp_tid = 4'd3;
        cycle();
        mem_rsp_valid = 0;
        cycle();
        cycle();
        chk("t3_8th_cnt", 64'(issued.size()), 64'd8);
        if (issued.size() == 8) chk("t3_8th_tid", 64'(issued[7]), 64'd3);
        drain();

        // pool exhaustion
        issued.delete();
        req_valid = 3'b001; req_we = 3'b000;
        repeat (18) cycle();
        chk("t4_issued_cnt", 64'(issued.size()), 64'd16);
        for (int k = 0; k < 16 && k < issued.size(); k++) chk("t4_tid_seq", 64'(issued[k]), 64'(k));
        chk("t4_full_stall", 64'(req_ready_o), 64'd0);
        mem_rsp_valid = 1; mem_rsp_tid = 4'd9;
        #1 chk("t4_no_same_cycle", 64'(req_ready_o), 64'd0);
        cycle();
        mem_rsp_valid = 0;
        #1 chk("t4_next_cycle", 64'(req_ready_o), 64'b001);
        cycle();
        cycle();
        chk("t4_17th_cnt", 64'(issued.size()), 64'd17);
        if (issued.size() == 17) chk("t4_17th_tid", 64'(issued[16]), 64'd9);
        drain();

        // backpressure hold and back-to-back release
        mem_req_ready = 0;
        req_valid = 3'b011; req_we = 3'b000;
        cycle();
        hold_addr = m_oaddr;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("t5_hold_tid", 64'(mem_req_tid_o), 64'd0);
            chk("t5_hold_addr", mem_req_addr_o, hold_addr);
            chk("t5_no_grant", 64'(last_ready), 64'd0);
        end
        issued.delete();
        mem_req_ready = 1;
        repeat (4) cycle();
        chk("t5_b2b", 64'(issued.size()), 64'd4);
        drain();

        // response to unused TID, then reset mid-traffic
        mem_rsp_valid = 1; mem_rsp_tid = 4'd5;
        #1 chk("t6_no_route", 64'(rsp_valid_o), 64'd0);
        cycle();
        mem_rsp_valid = 0;
        chk("t6_err_set", 64'(tid_err_o), 64'd1);
        repeat (2) cycle();
        chk("t6_err_sticky", 64'(tid_err_o), 64'd1);
        req_valid = 3'b011; req_we = 3'b010; mem_req_ready = 1;
        repeat (3) cycle();
        req_valid = '0;
        rst_n = 0;
        cycle();
        rst_n = 1;
        chk("t6_rst_valid", 64'(mem_req_valid_o), 64'd0);
        chk("t6_rst_tid", 64'(mem_req_tid_o), 64'd0);
        chk("t6_rst_addr", mem_req_addr_o, 64'd0);
        chk("t6_rst_err", 64'(tid_err_o), 64'd0);
        chk("t6_rst_idle", 64'(idle_o), 64'd1);
        mem_rsp_valid = 1; mem_rsp_tid = 4'd0;
        #1 chk("t6_late_no_route", 64'(rsp_valid_o), 64'd0);
        cycle();
        mem_rsp_valid = 0;
        chk("t6_late_err", 64'(tid_err_o), 64'd1);
        rst_n = 0;
        cycle();
        rst_n = 1;

        // random traffic
        for (int n = 0; n < 600; n++) begin
            int cand[$];
            req_valid = 3'($urandom_range(0, 7));
            req_we    = 3'($urandom_range(0, 7));
            for (int r = 0; r < 3; r++) begin
                req_addr[r*64 +: 64]  = {$urandom, $urandom};
                req_wdata[r*64 +: 64] = {$urandom, $urandom};
            end
            mem_req_ready = ($urandom_range(0, 3) != 0);
            for (int t = 0; t < NTID; t++)
                if (m_use[t] && !(m_ov && m_otid == 4'(t))) cand.push_back(t);
            mem_rsp_valid = 0;
            if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
                mem_rsp_valid = 1;
                mem_rsp_tid   = 4'(cand[$urandom_range(0, cand.size() - 1)]);
            end else if ($urandom_range(0, 63) == 0) begin
                mem_rsp_valid = 1;
                mem_rsp_tid   = 4'($urandom_range(0, 15));
            end
            cycle();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule
